// File: rtl/button_pulser_pkg.sv
// Shared constants for the push-button conditioning stage: channel indices,
// default timing parameters and a counter-width helper.
package button_pulser_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;

  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int REPEAT_DEFAULT   = 0;

  // Width needed to hold values 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: input synchronizer, debounce counter, stable level,
// press-edge detection and optional auto-repeat event generation.
module button_debounce
  import button_pulser_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int REPEAT   = REPEAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic ev
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam int RW = cnt_width(REPEAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT);

  logic          meta_r;
  logic          stable_r;
  logic          stable_d_r;
  logic [CW-1:0] cnt_r;
  logic [RW-1:0] rpt_r;

  logic          stable_s;
  logic [CW-1:0] cnt_s;
  logic [RW-1:0] rpt_s;
  logic          press_s;
  logic          repeat_s;

  // The counter and stable level form the second synchronizer stage, so a
  // raw sample taken at edge 1 can flip the level at edge DEBOUNCE+1.
  always_comb begin
    cnt_s    = cnt_r;
    stable_s = stable_r;
    if (meta_r == stable_r) begin
      cnt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_s    = '0;
      stable_s = ~stable_r;
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  assign press_s = stable_r & ~stable_d_r;

  // Repeat timer: loads on press, fires every REPEAT cycles, clears on release.
  always_comb begin
    rpt_s    = rpt_r;
    repeat_s = 1'b0;
    if (REPEAT == 0) begin
      rpt_s = '0;
    end else if (!stable_r) begin
      rpt_s = '0;
    end else if (press_s) begin
      rpt_s = RW'(1);
    end else if (rpt_r == RPT_LAST) begin
      repeat_s = 1'b1;
      rpt_s    = RW'(1);
    end else begin
      rpt_s = rpt_r + RW'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r     <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= '0;
      rpt_r      <= '0;
    end else begin
      meta_r     <= btn;
      stable_r   <= stable_s;
      stable_d_r <= stable_r;
      cnt_r      <= cnt_s;
      rpt_r      <= rpt_s;
    end
  end

  assign level = stable_r;
  assign ev    = press_s | repeat_s;

endmodule

// File: rtl/button_pulser.sv
// Two debounced button channels with arbitration so that shift_left and
// shift_right are clean, registered, mutually exclusive one-cycle strobes.
module button_pulser
  import button_pulser_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int REPEAT   = REPEAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       shift_left,
  output logic       shift_right,
  output logic [1:0] pressed
);

  logic [1:0] level_s;
  logic [1:0] ev_s;
  logic [1:0] shift_s;
  logic [1:0] shift_r;

  button_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)) u_left (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_left),
    .level (level_s[BTN_LEFT]),
    .ev    (ev_s[BTN_LEFT])
  );

  button_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)) u_right (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_right),
    .level (level_s[BTN_RIGHT]),
    .ev    (ev_s[BTN_RIGHT])
  );

  // An event passes only while the opposite stable level is low; since any
  // event implies its own level is high, both strobes can never fire at once.
  always_comb begin
    shift_s            = 2'b00;
    shift_s[BTN_LEFT]  = ev_s[BTN_LEFT]  & ~level_s[BTN_RIGHT];
    shift_s[BTN_RIGHT] = ev_s[BTN_RIGHT] & ~level_s[BTN_LEFT];
  end

  // Strobe output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= 2'b00;
    end else begin
      shift_r <= shift_s;
    end
  end

  assign shift_left  = shift_r[BTN_LEFT];
  assign shift_right = shift_r[BTN_RIGHT];
  assign pressed     = level_s;

endmodule

// File: tb/tb_button_pulser.sv
// Scoreboard bench: stimulus queues expected strobes (instance, direction,
// edge number); a negedge monitor pops and compares every strobe it sees.
module tb_button_pulser;

  logic       clk = 1'b0;
  logic       rst_a, bl_a, br_a, sl_a, sr_a;
  logic       rst_b, bl_b, br_b, sl_b, sr_b;
  logic [1:0] pr_a, pr_b;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  typedef struct {
    int inst;
    int dir;
    int edge_n;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  button_pulser #(.DEBOUNCE(4), .REPEAT(0)) dut_a (
    .clk(clk), .rst(rst_a), .btn_left(bl_a), .btn_right(br_a),
    .shift_left(sl_a), .shift_right(sr_a), .pressed(pr_a)
  );

  button_pulser #(.DEBOUNCE(2), .REPEAT(5)) dut_b (
    .clk(clk), .rst(rst_b), .btn_left(bl_b), .btn_right(br_b),
    .shift_left(sl_b), .shift_right(sr_b), .pressed(pr_b)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b, required %b (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  task automatic expect_strobe(input int inst, input int dir, input int e);
    exp_t x;
    x.inst   = inst;
    x.dir    = dir;
    x.edge_n = e;
    exp_q.push_back(x);
  endtask

  task automatic mon(input int inst, input logic l, input logic r);
    int idx;
    idx = -1;
    total++;
    if ((l & r) !== 1'b0) begin
      bad++;
      $display("FAIL exclusive inst=%0d: got l=%b r=%b at edge %0d, required not both", inst, l, r, edge_cnt);
    end
    if ((l | r) === 1'b1) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (idx < 0 && exp_q[i].inst == inst) idx = i;
      total++;
      if (idx < 0) begin
        bad++;
        $display("FAIL unexpected_strobe inst=%0d: got l=%b r=%b at edge %0d, required none", inst, l, r, edge_cnt);
      end else begin
        if (exp_q[idx].dir != (r ? 1 : 0) || exp_q[idx].edge_n != edge_cnt) begin
          bad++;
          $display("FAIL strobe inst=%0d: got dir=%0d edge=%0d, required dir=%0d edge=%0d",
                   inst, (r ? 1 : 0), edge_cnt, exp_q[idx].dir, exp_q[idx].edge_n);
        end
        exp_q.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, sl_a, sr_a);
    mon(1, sl_b, sr_b);
  end

  initial begin
    int base;
    logic [1:0] pat [8];
    rst_a = 1'b0; bl_a = 1'b0; br_a = 1'b0;
    rst_b = 1'b0; bl_b = 1'b0; br_b = 1'b0;
    cyc(2);
    chk("reset_pressed_a", pr_a, 2'b00);
    chk("reset_strobes_a", {sr_a, sl_a}, 2'b00);
    chk("reset_pressed_b", pr_b, 2'b00);
    chk("reset_strobes_b", {sr_b, sl_b}, 2'b00);
    rst_a = 1'b1;
    rst_b = 1'b1;
    cyc(3);

    // 1: single press, DEBOUNCE=4, REPEAT=0
    bl_a = 1'b1;
    base = edge_cnt + 1;
    expect_strobe(0, 0, base + 5);
    cyc(4);
    chk("t1_pressed_before", pr_a, 2'b00);
    cyc(1);
    chk("t1_pressed_edge5", pr_a, 2'b01);
    cyc(15);
    bl_a = 1'b0;
    cyc(8);
    chk("t1_released", pr_a, 2'b00);

    // 2: short bounce on right, then a real press
    pat = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      br_a = pat[i][0];
      cyc(1);
      chk("t2_bounce_pressed", pr_a, 2'b00);
    end
    cyc(6);
    chk("t2_after_bounce", pr_a, 2'b00);
    br_a = 1'b1;
    base = edge_cnt + 1;
    expect_strobe(0, 1, base + 5);
    cyc(12);
    chk("t2_right_pressed", pr_a, 2'b10);
    br_a = 1'b0;
    cyc(8);

    // 3: simultaneous press -> no strobes
    bl_a = 1'b1;
    br_a = 1'b1;
    cyc(20);
    chk("t3_both_pressed", pr_a, 2'b11);
    br_a = 1'b0;
    cyc(10);
    chk("t3_left_only", pr_a, 2'b01);
    bl_a = 1'b0;
    cyc(8);
    chk("t3_released", pr_a, 2'b00);

    // 6: reset while held; async clear, then fresh press strobe
    bl_a = 1'b1;
    base = edge_cnt + 1;
    expect_strobe(0, 0, base + 5);
    cyc(10);
    chk("t6_pressed_before_reset", pr_a, 2'b01);
    rst_a = 1'b0;
    #1;
    chk("t6_async_pressed", pr_a, 2'b00);
    chk("t6_async_strobes", {sr_a, sl_a}, 2'b00);
    cyc(3);
    rst_a = 1'b1;
    base = edge_cnt + 1;
    expect_strobe(0, 0, base + 5);
    cyc(4);
    chk("t6_pressed_before", pr_a, 2'b00);
    cyc(1);
    chk("t6_pressed_again", pr_a, 2'b01);
    cyc(5);
    bl_a = 1'b0;
    cyc(8);

    // 4: auto-repeat, DEBOUNCE=2, REPEAT=5
    bl_b = 1'b1;
    base = edge_cnt + 1;
    for (int k = 0; k < 6; k++) expect_strobe(1, 0, base + 3 + 5 * k);
    cyc(2);
    chk("t4_pressed_before", pr_b, 2'b00);
    cyc(1);
    chk("t4_pressed_edge3", pr_b, 2'b01);
    cyc(27);
    bl_b = 1'b0;
    cyc(10);
    chk("t4_released", pr_b, 2'b00);

    // 5: repeats suppressed while both held, resume after right release
    bl_b = 1'b1;
    base = edge_cnt + 1;
    expect_strobe(1, 0, base + 3);
    expect_strobe(1, 0, base + 8);
    expect_strobe(1, 0, base + 28);
    expect_strobe(1, 0, base + 33);
    expect_strobe(1, 0, base + 38);
    cyc(10);
    br_b = 1'b1;
    cyc(6);
    chk("t5_both_pressed", pr_b, 2'b11);
    cyc(6);
    br_b = 1'b0;
    cyc(14);
    chk("t5_left_held", pr_b, 2'b01);
    bl_b = 1'b0;
    cyc(10);
    chk("t5_released", pr_b, 2'b00);

    cyc(5);
    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL missing_strobe inst=%0d: got nothing, required dir=%0d at edge %0d",
               exp_q[0].inst, exp_q[0].dir, exp_q[0].edge_n);
      exp_q.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_pulser.md
Name: button_pulser

Overview:
- Upstream conditioning stage for the LED shifter. Takes two raw, asynchronous, bouncing push-buttons (left, right).
- Produces clean single-cycle shift_left / shift_right strobes, one per press, plus optional auto-repeat while a button is held.
- Enforces the shifter's "both pressed -> no shift" rule at the source: the two strobes are never asserted together.

Parameters:
- DEBOUNCE, 4: consecutive synchronized cycles an input must differ from its stable level before the stable level flips. Must be >= 1.
- REPEAT, 0: auto-repeat period in cycles while a button stays held. 0 disables auto-repeat. Nonzero values must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset); one clock domain only
- btn_left  input  1  raw left button, asynchronous, active-high, may bounce
- btn_right  input  1  raw right button, asynchronous, active-high, may bounce
- shift_left  output  1  one-cycle strobe, registered
- shift_right  output  1  one-cycle strobe, registered
- pressed  output  2  debounced levels {right, left}, registered

Behaviour:
- Reset (rst=0, asynchronous): synchronizers, counters, stable levels, repeat timers, shift_left, shift_right and pressed all go to 0 immediately.
- Synchronizer: each button passes through a 2-FF synchronizer. All logic downstream of it sees only the second flop.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE+1).
  - When the sync value equals the stable level, the counter clears to 0.
  - When it differs, the counter increments.
  - When the counter reaches DEBOUNCE, the stable level toggles and the counter clears. Any bounce before that clears the counter.
- Press event: the stable level goes 0->1.
  - Latency: if the raw input is sampled high at edge 1 and stays high, pressed[i] rises at edge DEBOUNCE+1 and the strobe is high for exactly the cycle after edge DEBOUNCE+2.
  - Release (1->0) produces no strobe. pressed[i] falls after the same debounce delay.
- Auto-repeat (REPEAT>0):
  - A per-channel timer loads at the press event.
  - While the stable level stays 1, a repeat event fires every REPEAT cycles, so strobes are spaced exactly REPEAT cycles apart.
  - The timer clears on release.
  - REPEAT=0 means exactly one strobe per press.
- Arbitration, evaluated on the same-cycle stable levels:
  - A left event produces shift_left only if the right stable level is 0. Right is symmetric.
  - Simultaneous press events produce no strobe on either output.
  - Holding one button and pressing the other suppresses all further strobes, including repeats, until one is released.
  - After that release, the remaining held button resumes repeats from its own timer. It gets no new press strobe.
- Invariant: shift_left & shift_right == 0 on every cycle.
- Reset mid-operation: all state is lost. A button held through reset release is re-debounced from scratch and yields a fresh press strobe DEBOUNCE+2 edges after reset deasserts.
- Bounce shorter than DEBOUNCE cycles, in either direction, never changes pressed and never generates a strobe.

Decomposition:
- Shared package holds:
  - button index constants BTN_LEFT=0, BTN_RIGHT=1
  - default DEBOUNCE / REPEAT values, also used by the top level to tie these defaults into the shifter instance
- One natural sub-module, button_debounce: synchronizer, debounce counter, stable level, press-edge and repeat-event generation. It is instantiated twice.
- Arbitration and the output registers live in button_pulser.

Test Plan:
1. DEBOUNCE=4, REPEAT=0: reset, then btn_left=1 held for 20 cycles -> shift_left high for exactly one cycle, 6 edges after the first high sample; pressed=2'b01 from edge 5; shift_right stays 0.
2. Bounce: btn_right toggles 1,0,1,0 with 2-cycle pulses, then 0 -> pressed stays 2'b00 and no strobe. Afterwards btn_right held high -> exactly one shift_right.
3. btn_left and btn_right rise on the same cycle and are held for 20 cycles -> no strobes, pressed=2'b11. Release right -> still no strobe (REPEAT=0).
4. DEBOUNCE=2, REPEAT=5: btn_left held for 30 cycles -> first strobe at edge 4, then strobes every 5 cycles (edges 9, 14, 19, ...). Release -> strobes stop.
5. btn_left held with repeats running; press btn_right -> repeats suppressed while both are stable high. Release btn_right -> left repeats resume, and shift_right is never asserted.
6. btn_left held; assert rst=0 mid-debounce for 3 cycles (outputs clear asynchronously, before the next clk edge); release rst with btn_left still high -> one shift_left, DEBOUNCE+2 edges later.
